// File: rtl/uart_debug_pkg.sv
// Shared constants and types for the debug telemetry UART transmitter.
package uart_debug_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  function automatic logic [7:0] frame_checksum(input logic [7:0] a, input logic [7:0] b);
    return SYNC_BYTE ^ a ^ b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One 8N1 byte per valid/ready handshake; ready also rises on the last stop-bit
// cycle so a following byte starts with no gap.
module uart_tx_byte
  import uart_debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_done;

  assign bit_done = (cnt_q == '0);
  assign ready_o  = (state_q == IDLE) || ((state_q == STOP) && bit_done);
  assign tx_o     = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_done ? cnt_q : cnt_q - 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (valid_i) begin
          state_d = START;
          tx_d    = 1'b0;
          cnt_d   = CNT_LOAD;
          shift_d = data_i;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          cnt_d     = CNT_LOAD;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = CNT_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (valid_i) begin
            state_d = START;
            tx_d    = 1'b0;
            cnt_d   = CNT_LOAD;
            shift_d = data_i;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_debug_tx.sv
// Snapshots two status bytes on each trigger rising edge and sends
// {SYNC, A, B, checksum} over UART 8N1; edges seen while busy are counted.
module uart_debug_tx
  import uart_debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trigger,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  output logic       tx,
  output logic       busy,
  output logic [7:0] dropped_cnt
);

  localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

  logic       trig_q;
  logic       busy_q, busy_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] byte1_q, byte1_d;
  logic [7:0] byte2_q, byte2_d;
  logic [7:0] byte3_q, byte3_d;
  logic [7:0] dropped_q, dropped_d;

  logic       rise, accept, byte_ready, byte_valid;
  logic [7:0] byte_data, next_byte;

  assign rise   = trigger & ~trig_q;
  assign accept = rise & ~busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      idx_q     <= '0;
      byte1_q   <= '0;
      byte2_q   <= '0;
      byte3_q   <= '0;
      dropped_q <= '0;
    end else begin
      trig_q    <= trigger;
      busy_q    <= busy_d;
      idx_q     <= idx_d;
      byte1_q   <= byte1_d;
      byte2_q   <= byte2_d;
      byte3_q   <= byte3_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    unique case (idx_q)
      2'd0:    next_byte = byte1_q;
      2'd1:    next_byte = byte2_q;
      default: next_byte = byte3_q;
    endcase
  end

  // Byte 0 goes out straight from the accept cycle so the start bit lands next cycle.
  always_comb begin
    busy_d     = busy_q;
    idx_d      = idx_q;
    byte1_d    = byte1_q;
    byte2_d    = byte2_q;
    byte3_d    = byte3_q;
    dropped_d  = dropped_q;
    byte_valid = 1'b0;
    byte_data  = next_byte;
    if (accept) begin
      busy_d     = 1'b1;
      idx_d      = '0;
      byte1_d    = data_a;
      byte2_d    = data_b;
      byte3_d    = frame_checksum(data_a, data_b);
      byte_valid = 1'b1;
      byte_data  = SYNC_BYTE;
    end else if (busy_q && byte_ready) begin
      if (idx_q == LAST_IDX) begin
        busy_d = 1'b0;
      end else begin
        byte_valid = 1'b1;
        idx_d      = idx_q + 2'd1;
      end
    end
    if (rise && busy_q && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_i(byte_valid),
    .data_i (byte_data),
    .ready_o(byte_ready),
    .tx_o   (tx)
  );

  assign busy        = busy_q;
  assign dropped_cnt = dropped_q;

endmodule

// File: doc/uart_debug_tx.md
Name: uart_debug_tx

Overview:
- Telemetry transmitter for the FPGA build. It drives the board's usb_tx line, which is currently unused.
- On each rising edge of the prescaled model clock it snapshots two status bytes (the mimosa uo_out and debug outputs).
- It sends them to the host as a 4-byte UART 8N1 frame: sync byte, byte A, byte B, XOR checksum.
- It runs in the 100 MHz clk domain. It is instantiated in the FPGA top beside the model-clock divider.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.

Ports:
- clk  input  1  main clock, 100 MHz.
- rst_n  input  1  reset, asynchronous, active-low.
- trigger  input  1  prescaled model clock, synchronous to clk; a frame starts on its rising edge.
- data_a  input  8  first payload byte (uo_out); sampled on the accepted trigger edge.
- data_b  input  8  second payload byte (debug); sampled on the accepted trigger edge.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high while a frame is in flight.
- dropped_cnt  output  8  saturating count of trigger edges rejected because busy was high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tx=1, busy=0, dropped_cnt=0.
  - FSM goes to IDLE; edge-detect register is cleared to 0.
  - Reset mid-frame aborts the frame immediately: tx returns high and nothing resumes after release.
- Edge detection:
  - trig_q is trigger registered once.
  - A rising edge is the cycle where trigger=1 and trig_q=0.
  - trigger held high out of reset produces one edge on the first cycle after release.
- Accept: an edge is accepted only in state IDLE. On that cycle the block latches:
  - byte0 = SYNC (0xA5)
  - byte1 = data_a
  - byte2 = data_b
  - byte3 = 0xA5 ^ data_a ^ data_b
- Latency: accepted edge at cycle N → tx=0 (start bit of byte0) and busy=1 from cycle N+1.
- Reject: an edge while not IDLE increments dropped_cnt. It saturates at 0xFF and never wraps. Frame contents are unaffected.
- FSM states and transitions:
  - IDLE → START: on accept; tx=1 while in IDLE.
  - START → DATA: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=bit[i] for CLKS_PER_BIT cycles each, LSB first, i=0..7; after bit 7 → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte_idx<3, increment byte_idx → START. If byte_idx=3 → IDLE.
- No inter-byte gap beyond the single stop bit.
- Timing:
  - A frame is exactly 40*CLKS_PER_BIT cycles of busy=1.
  - busy falls on the first cycle tx is back in IDLE.
- Edge on the final cycle of the last stop bit: FSM is still STOP, so the edge is dropped (counted). An edge one cycle later is accepted.
- Baud counter:
  - Loads CLKS_PER_BIT-1 on each bit start and decrements to 0.
  - Bit advance happens on count 0.
  - Width is $clog2(CLKS_PER_BIT).
- tx is driven from a register (glitch-free).

Decomposition:
- Package uart_debug_pkg:
  - SYNC_BYTE=8'hA5
  - FRAME_BYTES=4
  - state enum {IDLE, START, DATA, STOP}
- Sub-module uart_tx_byte:
  - Handles one 8N1 byte with valid/ready handshake plus the baud counter.
  - The top holds edge detect, frame latch, byte sequencing, checksum and dropped_cnt.
  - The bit-level timing above must hold regardless of this split.

Test Plan (CLKS_PER_BIT=4):
- Reset check: assert reset → tx=1, busy=0, dropped_cnt=0. Then hold trigger=0 for 200 cycles → tx stays 1.
- Single frame: data_a=0x3C, data_b=0x0F, one trigger rising edge at cycle N →
  - tx low at N+1
  - UART monitor decodes A5 3C 0F 96
  - busy high for exactly 160 cycles
- Overrun: second trigger edge 50 cycles into the frame → frame unchanged, dropped_cnt=1. 300 extra edges during long back-to-back activity → dropped_cnt saturates at 0xFF.
- Boundary at busy fall:
  - Edge on the last stop-bit cycle → dropped_cnt increments, no new frame.
  - Edge on the first IDLE cycle → new frame starts the next cycle.
- Data capture timing: change data_a to 0xFF one cycle after the accepted edge → frame still carries the value sampled at the edge.
- Mid-frame reset: assert rst_n=0 during byte1 data bits → tx=1 asynchronously. After release with trigger=0, no further frame is sent.
